// File: rtl/arbiter_rr_n.sv
// N-way round-robin mutex arbiter with grant locking and zero-dead-cycle handover.
// Define ARB_HOLD_TIMEOUT_EN to compile in revocation of grants held for MAX_HOLD cycles.
module arbiter_rr_n #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               revoked
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_grant_valid;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    r_ptr;

  logic [NUM_REQ-1:0] w_cand;
  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_win_next;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_release;
  logic               w_expire;
  logic               w_take;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_revoked;
`endif

  // The current owner never competes for its own handover, so it drops to lowest priority.
  // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    w_cand  = req;
    w_found = 1'b0;
    w_win   = '0;
    if (r_state == BUSY) w_cand[r_grant_id] = 1'b0;
    // NOTE: blocking assignments here on purpose; w_found must update within the loop.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && w_cand[i] && ((int'(r_ptr) + k) % NUM_REQ == i)) begin
          w_found = 1'b1;
          w_win   = ID_W'(i);
        end
      end
    end
  end

  assign w_win_next = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
  assign w_win_oh   = NUM_REQ'(1) << w_win;
  assign w_release  = (r_state == BUSY) && !req[r_grant_id];

`ifdef ARB_HOLD_TIMEOUT_EN
  assign w_expire = (r_state == BUSY) && req[r_grant_id] && (r_hold_cnt >= HOLD_LAST);
`else
  assign w_expire = 1'b0;
`endif

  assign w_take = w_found && ((r_state == IDLE) || w_release || w_expire);

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_ptr         <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
      r_hold_cnt    <= '0;
      r_revoked     <= 1'b0;
`endif
    end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
      r_revoked <= w_take && w_expire;
`endif
      if (w_take) begin
        r_state       <= BUSY;
        r_grant       <= w_win_oh;
        r_grant_valid <= 1'b1;
        r_grant_id    <= w_win;
        r_ptr         <= w_win_next;
`ifdef ARB_HOLD_TIMEOUT_EN
        r_hold_cnt    <= '0;
`endif
      end else if (w_release) begin
        r_state       <= IDLE;
        r_grant       <= '0;
        r_grant_valid <= 1'b0;
        r_grant_id    <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
        r_hold_cnt    <= '0;
`endif
      end
`ifdef ARB_HOLD_TIMEOUT_EN
      else if ((r_state == BUSY) && (r_hold_cnt != HOLD_SAT)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
`endif
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
`ifdef ARB_HOLD_TIMEOUT_EN
  assign revoked     = r_revoked;
`else
  assign revoked     = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Self-checking bench for arbiter_rr_n: directed scenarios plus randomized traffic
// compared each cycle against an owner/pointer reference model.
module tb_arbiter_rr_n;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int SPARSE_HOLD = 2;
`else
  localparam int SPARSE_HOLD = 5;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         revoked;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: owner index (-1 = none), priority pointer, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_rev   = 1'b0;

  arbiter_rr_n #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .revoked     (revoked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // First requester in round-robin order starting at m_ptr, skipping index excl.
  function automatic int pick(input logic [N-1:0] r, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % N;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic rn);
    int w;
    m_rev = 1'b0;
    if (!rn) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      w = pick(r, -1);
      if (w >= 0) grant_to(w);
    end else if (!r[m_owner]) begin
      w = pick(r, m_owner);
      if (w >= 0) grant_to(w);
      else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
      w = pick(r, m_owner);
      if (m_cnt >= MAX_HOLD - 1 && w >= 0) begin
        grant_to(w);
        m_rev = 1'b1;
      end else if (m_cnt < MAX_HOLD) begin
        m_cnt++;
      end
`endif
    end
  endtask

  // Apply inputs for one clock, advance the model, and compare all outputs.
  task automatic cycle(input logic [N-1:0] r, input logic rn);
    logic [N-1:0] exp_g;
    req   = r;
    rst_n = rn;
    @(posedge clk);
    model_step(r, rn);
    #1;
    exp_g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("grant",       32'(grant),                32'(exp_g));
    check("grant_valid", 32'(grant_valid),          32'(m_owner >= 0));
    check("grant_id",    32'(grant_id),             32'((m_owner >= 0) ? m_owner : 0));
    check("revoked",     32'(revoked),              32'(m_rev));
    check("onehot0",     32'($countones(grant) <= 1), 32'(1));
  endtask

  initial begin
    logic [N-1:0] seq [5];
    logic [N-1:0] r;
    logic         rn;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with all requesting, then first grant goes to index 0.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0);
      check("rst_grant", 32'(grant), 32'(0));
    end
    cycle(4'b1111, 1'b1);
    check("rst_exit_grant", 32'(grant), 32'(4'b0001));
    check("rst_exit_id",    32'(grant_id), 32'(0));

`ifndef ARB_HOLD_TIMEOUT_EN
    // Lock: owner keeps the grant while its request stays high.
    for (int i = 0; i < 19; i++) cycle(4'b1111, 1'b1);
    check("lock", 32'(grant), 32'(4'b0001));
`endif

    // Round-robin with wrap-around and no idle gap on handover.
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b1);
    for (int j = 1; j < 5; j++) begin
      cycle(4'b1111 & ~seq[j-1], 1'b1);
      check("rr_handover", 32'(grant), 32'(seq[j]));
      cycle(4'b1111, 1'b1);
      check("rr_hold", 32'(grant), 32'(seq[j]));
    end

    // Sparse requests.
    cycle(4'b0000, 1'b0);
    cycle(4'b1000, 1'b1);
    check("sparse_first", 32'(grant), 32'(4'b1000));
    for (int i = 0; i < SPARSE_HOLD; i++) cycle(4'b1001, 1'b1);
    check("sparse_locked", 32'(grant), 32'(4'b1000));
    cycle(4'b0001, 1'b1);
    check("sparse_next", 32'(grant), 32'(4'b0001));

`ifdef ARB_HOLD_TIMEOUT_EN
    // Timeout revocation, then a sole requester keeps its grant indefinitely.
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b1);
    check("to_first", 32'(grant), 32'(4'b0001));
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0011, 1'b1);
      check("to_hold", 32'(grant), 32'(4'b0001));
    end
    cycle(4'b0011, 1'b1);
    check("to_revoke_grant", 32'(grant), 32'(4'b0010));
    check("to_revoke_pulse", 32'(revoked), 32'(1));
    cycle(4'b0001, 1'b1);
    for (int i = 0; i < 8; i++) cycle(4'b0001, 1'b1);
    check("to_sole", 32'(grant), 32'(4'b0001));
    check("to_sole_pulse", 32'(revoked), 32'(0));
`endif

    // Mid-grant reset drops the grant and restarts the pointer at 0.
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b1);
    check("mid_pre", 32'(grant), 32'(4'b0100));
    cycle(4'b0100, 1'b0);
    check("mid_reset", 32'(grant), 32'(0));
    cycle(4'b0101, 1'b1);
    check("mid_after", 32'(grant), 32'(4'b0001));

    // Randomized traffic: requests mostly stable, occasional changes and resets.
    r = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      rn = ($urandom_range(0, 49) != 0);
      cycle(r, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
